// File: rtl/mdio_master_param_if.sv
// ============================================================================
// Module  : mdio_master_param_if
// Brief   : Host and pad signal bundle for the MDIO management master.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface mdio_master_param_if;
  logic        mdio_start;
  logic [31:0] t_data;
  logic        mdio_in;
  logic        mdc;
  logic        mdio_out;
  logic        mdio_oe;
  logic [15:0] rd_data;
  logic        data_rdy;
  logic        busy;
  logic        ta_err;

  modport master (
    input  mdio_start, t_data, mdio_in,
    output mdc, mdio_out, mdio_oe, rd_data, data_rdy, busy, ta_err
  );

  modport slave (
    output mdio_start, t_data, mdio_in,
    input  mdc, mdio_out, mdio_oe, rd_data, data_rdy, busy, ta_err
  );
endinterface

`default_nettype wire

// File: rtl/mdio_master_param.sv
// ============================================================================
// Module  : mdio_master_param
// Brief   : MDIO master with MDC divider, optional preamble, C22/C45 frames.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mdio_master_param #(
  parameter int MDC_DIV = 2,
  parameter int PRE_LEN = 32
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  mdio_master_param_if.master   bus
);

  localparam int c_div_w = (MDC_DIV > 1) ? $clog2(MDC_DIV) : 1;
  localparam int c_pre_w = (PRE_LEN > 1) ? $clog2(PRE_LEN) : 1;
  localparam logic [c_div_w-1:0] c_div_last = c_div_w'(MDC_DIV - 1);
  localparam logic [c_pre_w-1:0] c_pre_last = c_pre_w'((PRE_LEN > 0) ? PRE_LEN - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PREAMBLE = 2'd1,
    S_FRAME    = 2'd2
  } state_t;

  state_t               r_state;
  logic [c_div_w-1:0]   r_div_cnt;
  logic                 r_high;
  logic [c_pre_w-1:0]   r_pre_cnt;
  logic [4:0]           r_bit_idx;
  logic [31:0]          r_frame;
  logic [15:0]          r_hold;
  logic                 r_mdc;
  logic                 r_mdio_out;
  logic                 r_mdio_oe;
  logic [15:0]          r_rd_data;
  logic                 r_data_rdy;
  logic                 r_busy;
  logic                 r_ta_err;

  logic                 w_read;
  logic                 w_half_end;

  assign w_read     = r_frame[29];
  assign w_half_end = (r_div_cnt == c_div_last);

  // Returns {oe, out}: read frames release the pad from the TA field onwards.
  function automatic logic [1:0] bit_drive(input logic [31:0] frame, input logic [4:0] idx);
    if (frame[29] && (idx <= 5'd17))
      return 2'b00;
    return {1'b1, frame[idx]};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_div_cnt  <= '0;
      r_high     <= 1'b0;
      r_pre_cnt  <= '0;
      r_bit_idx  <= '0;
      r_frame    <= '0;
      r_hold     <= '0;
      r_mdc      <= 1'b0;
      r_mdio_out <= 1'b0;
      r_mdio_oe  <= 1'b0;
      r_rd_data  <= '0;
      r_data_rdy <= 1'b0;
      r_busy     <= 1'b0;
      r_ta_err   <= 1'b0;
    end else begin
      r_data_rdy <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.mdio_start) begin
            r_frame   <= bus.t_data;
            r_busy    <= 1'b1;
            r_ta_err  <= 1'b0;
            r_div_cnt <= '0;
            r_high    <= 1'b0;
            r_mdc     <= 1'b0;
            r_pre_cnt <= '0;
            r_bit_idx <= 5'd31;
            if (PRE_LEN > 0) begin
              r_state                 <= S_PREAMBLE;
              {r_mdio_oe, r_mdio_out} <= 2'b11;
            end else begin
              r_state                 <= S_FRAME;
              {r_mdio_oe, r_mdio_out} <= bit_drive(bus.t_data, 5'd31);
            end
          end
        end

        S_PREAMBLE, S_FRAME: begin
          if (!w_half_end) begin
            r_div_cnt <= r_div_cnt + 1'b1;
          end else begin
            r_div_cnt <= '0;
            if (!r_high) begin
              // Rising MDC edge: the PHY's bit is captured here.
              r_high <= 1'b1;
              r_mdc  <= 1'b1;
              if ((r_state == S_FRAME) && w_read) begin
                if (r_bit_idx == 5'd16)
                  r_ta_err <= bus.mdio_in;
                if (r_bit_idx <= 5'd15)
                  r_hold <= {r_hold[14:0], bus.mdio_in};
              end
            end else begin
              r_high <= 1'b0;
              r_mdc  <= 1'b0;
              if (r_state == S_PREAMBLE) begin
                if (r_pre_cnt == c_pre_last) begin
                  r_state                 <= S_FRAME;
                  r_bit_idx               <= 5'd31;
                  {r_mdio_oe, r_mdio_out} <= bit_drive(r_frame, 5'd31);
                end else begin
                  r_pre_cnt <= r_pre_cnt + 1'b1;
                end
              end else if (r_bit_idx == 5'd0) begin
                r_state    <= S_IDLE;
                r_busy     <= 1'b0;
                r_mdio_oe  <= 1'b0;
                r_mdio_out <= 1'b0;
                if (w_read) begin
                  r_rd_data  <= r_hold;
                  r_data_rdy <= 1'b1;
                end
              end else begin
                r_bit_idx               <= r_bit_idx - 5'd1;
                {r_mdio_oe, r_mdio_out} <= bit_drive(r_frame, r_bit_idx - 5'd1);
              end
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.mdc      = r_mdc;
  assign bus.mdio_out = r_mdio_out;
  assign bus.mdio_oe  = r_mdio_oe;
  assign bus.rd_data  = r_rd_data;
  assign bus.data_rdy = r_data_rdy;
  assign bus.busy     = r_busy;
  assign bus.ta_err   = r_ta_err;

endmodule

`default_nettype wire

// File: doc/mdio_master_param.md
# mdio_master_param

Parametrised MDIO management master: serialises one 32-bit management frame per request onto MDC/MDIO. It adds a configurable MDC divider, configurable or suppressed preamble, and both Clause 22 and Clause 45 frames. Read frames include a turnaround check. It sits between the host register logic, which supplies T_DATA/MDIO_START, and the external PHY pad (MDIO_OUT/MDIO_OE/MDIO_IN tri-state).

## Interface
- MDC_DIV, 2, CLK cycles per MDC half-period; legal values ≥1.
- PRE_LEN, 32, number of preamble '1' bits sent before the frame; legal range 0..32; 0 means preamble suppressed.

- CLK  in  1  system clock; all logic on rising edge.
- RESET  in  1  asynchronous, active-low reset.
- MDIO_START  in  1  level request; sampled only in IDLE.
- T_DATA  in  32  frame: [31:30] ST, [29:28] OP, [27:23] PHYAD/PRTAD, [22:18] REGAD/DEVAD, [17:16] TA, [15:0] DATA/ADDRESS.
- MDIO_IN  in  1  MDIO pad input.
- MDC  out  1  management clock.
- MDIO_OUT  out  1  MDIO pad output data.
- MDIO_OE  out  1  pad output enable; 1 = master drives.
- RD_DATA  out  16  last read data.
- DATA_RDY  out  1  one-CLK pulse: RD_DATA/TA_ERR valid.
- BUSY  out  1  transaction in progress.
- TA_ERR  out  1  PHY failed to drive 0 on second TA bit of last read.

## Operation
- States: IDLE, PREAMBLE, FRAME.
- IDLE → PREAMBLE (→ FRAME directly if PRE_LEN=0) on a rising edge with MDIO_START=1.
  - That edge captures T_DATA into a shift register, sets BUSY=1 and clears TA_ERR.
  - T_DATA changes after capture are ignored.
- Read frame: T_DATA[29] (OP[1]) = 1, i.e. C22 read (10), C45 read (11) or C45 post-read-increment (10). Otherwise write/address frame.
- Each bit takes one MDC period: MDC low for MDC_DIV CLKs, then high for MDC_DIV CLKs.
  - MDIO_OUT/MDIO_OE change only at the start of the low half.
  - MDIO_IN is registered on the CLK edge that drives MDC 0→1.
- PREAMBLE: PRE_LEN bits, MDIO_OUT=1, MDIO_OE=1.
- FRAME: bits 31 down to 0.
  - Write: MDIO_OE=1 throughout; MDIO_OUT = T_DATA bit; the TA field is sent as supplied.
  - Read: MDIO_OE=1 for bits 31..18; MDIO_OE=0 from bit 17 through bit 0; MDIO_OUT=0 while OE=0.
  - Read, bit 16 sample = 1 → TA_ERR=1.
  - Read, bits 15..0 samples shift MSB-first into a holding register.
- End: after the high half of bit 0, return to IDLE.
  - MDC=0, MDIO_OE=0, MDIO_OUT=0, BUSY=0.
  - Read only: RD_DATA ← holding register and DATA_RDY=1 for exactly that one CLK. RD_DATA is updated even when TA_ERR=1.
  - Write: DATA_RDY stays 0 and RD_DATA is unchanged.
- MDIO_START held high: the next transaction is captured on the CLK after BUSY falls, giving a minimum of one IDLE CLK between frames.
- In IDLE, MDC is held at 0 (no free-running clock).

## Timing
- Reset (asynchronous, any state, including mid-frame): MDC=0, MDIO_OUT=0, MDIO_OE=0, BUSY=0, DATA_RDY=0, TA_ERR=0, RD_DATA=16'h0000, state=IDLE, counters cleared.
- First bit is driven on the capture edge (edge 0), with MDC=0. MDC first rises at edge MDC_DIV.
- Transaction length N = (PRE_LEN+32)·2·MDC_DIV CLKs. BUSY=1 from edge 0; BUSY=0 and the DATA_RDY pulse occur at edge N.
- Read sample for frame bit k is taken at edge (PRE_LEN+31−k)·2·MDC_DIV + MDC_DIV.
- MDC duty cycle is exactly 50%; period is 2·MDC_DIV CLKs.
- MDIO_START during BUSY is ignored and not queued.

## Test plan
- Reset/idle: assert RESET=0 mid-preamble → all outputs 0 in the same cycle (asynchronous); release with MDIO_START=0 → MDC stays 0 and BUSY stays 0.
- C22 write, MDC_DIV=2, PRE_LEN=32, T_DATA=32'h508AABCD → 32 ones then bits 0101_00001_00010_10_ABCD MSB-first; OE=1 throughout; BUSY falls at edge 256; DATA_RDY never asserted.
- C22 read, T_DATA=32'h60880000, PHY model drives 0 at bit 16 and 16'h1234 → OE drops at bit 17; RD_DATA=16'h1234; DATA_RDY one pulse at edge 256; TA_ERR=0.
- Read with no PHY (MDIO_IN=1) → RD_DATA=16'hFFFF, TA_ERR=1, DATA_RDY pulses once; next start clears TA_ERR.
- PRE_LEN=0, MDC_DIV=1, C45 read T_DATA=32'h30880000 → no preamble; frame length 64 CLKs; MDC period 2 CLKs.
- MDIO_START held high for three frames → frames back-to-back with exactly one IDLE CLK between; a T_DATA change mid-frame does not affect the frame in progress.
